// File: rtl/pipelined_wide_adder.sv
// pipelined_wide_adder: WIDTH-bit add/subtract split into CHUNK-bit slices,
// one slice per pipeline stage, with the carry registered between stages.
// Valid/ready handshake with a single global advance enable: when the result
// at the tail is stalled, the whole pipe (bubbles included) holds.
module pipelined_wide_adder #(
  parameter int WIDTH = 256,
  parameter int CHUNK = 64,
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);
  // Pipeline depth; WIDTH is expected to be a multiple of CHUNK.
  localparam int STAGES = WIDTH / CHUNK;

  // Per-stage state. a/b carry the (already inverted for subtract) operands
  // forward so later stages can consume their slice and the tail can see the
  // sign bits; sum accumulates finished slices; c is the inter-stage carry.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             sub;
    logic [TAG_W-1:0] tag;
  } stg_t;

  logic en;

  // Whole pipe advances unless a finished result is waiting on the consumer.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    stg_t           src;
    stg_t           stg_d;
    stg_t           stg_q;
    logic           vld_src;
    logic           vld_q;
    logic [CHUNK:0] add_w;

    if (k == 0) begin : g_head
      // Subtract is A + ~B + ~borrow_in, so invert B and the carry-in here.
      assign src = '{a:   in_a,
                     b:   in_sub ? ~in_b : in_b,
                     sum: '0,
                     c:   in_sub ^ in_cin,
                     sub: in_sub,
                     tag: in_tag};
      assign vld_src = in_valid;
    end else begin : g_body
      assign src     = g_stg[k-1].stg_q;
      assign vld_src = g_stg[k-1].vld_q;
    end

    // The only adder in this stage: one CHUNK-wide slice plus carry.
    assign add_w = {1'b0, src.a[k*CHUNK +: CHUNK]}
                 + {1'b0, src.b[k*CHUNK +: CHUNK]}
                 + {{CHUNK{1'b0}}, src.c};

    // Merge this stage's slice and carry into the forwarded state.
    always_comb begin
      stg_d                       = src;
      stg_d.sum[k*CHUNK +: CHUNK] = add_w[CHUNK-1:0];
      stg_d.c                     = add_w[CHUNK];
    end

    // Stage register: cleared on reset, frozen while the tail is stalled.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        stg_q <= '0;
        vld_q <= 1'b0;
      end else if (en) begin
        stg_q <= stg_d;
        vld_q <= vld_src;
      end
    end
  end

  // Tail stage drives the outputs; all-zero state after reset gives zero flags.
  assign out_valid = g_stg[STAGES-1].vld_q;
  assign out_sum   = g_stg[STAGES-1].stg_q.sum;
  assign out_tag   = g_stg[STAGES-1].stg_q.tag;
  // Carry-out of A + ~B + ~bin is the inverse of the borrow-out.
  assign out_cout  = g_stg[STAGES-1].stg_q.sub ^ g_stg[STAGES-1].stg_q.c;
  // Signed overflow: like-signed effective operands with a differently-signed result.
  assign out_ovf   = (g_stg[STAGES-1].stg_q.a[WIDTH-1] == g_stg[STAGES-1].stg_q.b[WIDTH-1])
                  && (g_stg[STAGES-1].stg_q.sum[WIDTH-1] != g_stg[STAGES-1].stg_q.a[WIDTH-1]);

endmodule

// File: tb/tb_pipelined_wide_adder.sv
// Bench for pipelined_wide_adder: scoreboard queue filled on accept, drained
// and compared on pop, plus latency, stall-hold and reset checks.
module tb_pipelined_wide_adder;
  localparam int W  = 256;
  localparam int C  = 64;
  localparam int TW = 8;
  localparam int ST = W / C;

  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          in_valid, in_ready, in_cin, in_sub;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0]  out_sum;
  logic [TW-1:0] out_tag;

  pipelined_wide_adder #(.WIDTH(W), .CHUNK(C), .TAG_W(TW)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   npop = 0;
  int   first_pop = 0;
  int   last_pop = 0;
  int   last_acc = 0;
  exp_t q[$];

  logic          hold_q = 1'b0;
  logic [W-1:0]  hold_sum;
  logic          hold_cout, hold_ovf;
  logic [TW-1:0] hold_tag;

  task automatic chk(input string nm, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, obs, exp, cyc);
    end
  endtask

  // Reference: plain W+1-bit arithmetic, borrow by unsigned compare.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sb, input logic [TW-1:0] tg);
    exp_t       e;
    logic [W:0] f;
    if (!sb) begin
      f      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      e.cout = f[W];
    end else begin
      f      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, ci};
      e.cout = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, ci}));
    end
    e.sum = f[W-1:0];
    e.ovf = sb ? ((a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]))
               : ((a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]));
    e.tag = tg;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock cycle: drive, sample mid-cycle, score, then advance.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic sb, input logic [TW-1:0] tg,
                      input logic ordy, output logic acc);
    exp_t e;
    in_valid = v; in_a = a; in_b = b; in_cin = ci; in_sub = sb; in_tag = tg;
    out_ready = ordy;
    #1;
    if (hold_q) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, hold_sum);
      chk("hold_cout", out_cout, hold_cout);
      chk("hold_ovf", out_ovf, hold_ovf);
      chk("hold_tag", out_tag, hold_tag);
    end
    chk("in_ready", in_ready, (!out_valid || out_ready));
    if (out_valid && out_ready) begin
      chk("sb_nonempty", (q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", out_sum, e.sum);
        chk("cout", out_cout, e.cout);
        chk("ovf", out_ovf, e.ovf);
        chk("tag", out_tag, e.tag);
      end
      if (npop == 0) first_pop = cyc;
      last_pop = cyc;
      npop++;
    end
    acc = v && in_ready;
    if (acc) begin
      q.push_back(model(a, b, ci, sb, tg));
      last_acc = cyc;
    end
    hold_q = out_valid && !out_ready;
    hold_sum = out_sum; hold_cout = out_cout; hold_ovf = out_ovf; hold_tag = out_tag;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, '0, '0, 1'b0, 1'b0, '0, ordy, acc);
  endtask

  // Offer one op, holding it until accepted (bounded).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                      input logic sb, input logic [TW-1:0] tg);
    logic acc = 1'b0;
    int   n = 0;
    while (!acc && n < 50) begin
      step(1'b1, a, b, ci, sb, tg, 1'b1, acc);
      n++;
    end
    chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      idle(1'b1);
      n++;
    end
    chk("drain", q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    q.delete();
    hold_q = 1'b0;
    npop = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", out_sum, 0);
    chk("rst_cout", out_cout, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_tag", out_tag, 0);
  endtask

  logic [W-1:0] ones, msb, ta[10], tb[10];
  logic         tci[10], tsb[10];

  initial begin
    ones = '1;
    msb  = '0;
    msb[W-1] = 1'b1;
    reset_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
    in_sub = 1'b0; in_tag = '0; out_ready = 1'b1;
    @(posedge clock);
    do_reset();

    // 1: carry ripples through every stage; latency equals stage count
    npop = 0;
    send(ones, '0, 1'b1, 1'b0, 8'hA1);
    for (int n = 0; n < 20 && npop == 0; n++) idle(1'b1);
    chk("lat_ripple", first_pop - last_acc, ST);
    drain();

    // 2: subtract / borrow
    send(256'd5, 256'd7, 1'b0, 1'b1, 8'h21);
    send(256'd7, 256'd5, 1'b1, 1'b1, 8'h22);
    // 3: signed overflow both directions
    send(~msb, 256'd1, 1'b0, 1'b0, 8'h31);
    send(msb, 256'd1, 1'b0, 1'b1, 8'h32);
    send(ones, ones, 1'b1, 1'b1, 8'h33);
    drain();

    // 4: backpressure, out_ready low in cycles 6..9 of the stream
    for (int i = 0; i < 10; i++) begin
      ta[i] = rnd(); tb[i] = rnd(); tci[i] = 1'($urandom); tsb[i] = 1'($urandom);
    end
    npop = 0;
    begin
      int   i = 0;
      logic acc;
      for (int t = 0; t < 80; t++) begin
        if (i < 10) step(1'b1, ta[i], tb[i], tci[i], tsb[i], TW'(i), !(t >= 6 && t <= 9), acc);
        else        step(1'b0, '0, '0, 1'b0, 1'b0, '0, !(t >= 6 && t <= 9), acc);
        if (acc) i++;
        if (i == 10 && q.size() == 0) break;
      end
      chk("bp_sent", i, 10);
      chk("bp_popped", npop, 10);
    end

    // 5: full throughput, 100 back-to-back ops
    npop = 0;
    begin
      int   first_acc = 0;
      logic acc;
      for (int i = 0; i < 100; i++) begin
        step(1'b1, rnd(), rnd(), 1'($urandom), 1'($urandom), TW'(i), 1'b1, acc);
        chk("tput_accept", acc, 1);
        if (i == 0) first_acc = last_acc;
      end
      drain();
      chk("tput_count", npop, 100);
      chk("tput_span", last_pop - first_pop, 99);
      chk("tput_lat", first_pop - first_acc, ST);
    end

    // 6: reset with ops in flight; nothing stale may emerge afterwards
    send(rnd(), rnd(), 1'b0, 1'b0, 8'h61);
    send(rnd(), rnd(), 1'b1, 1'b1, 8'h62);
    send(rnd(), rnd(), 1'b0, 1'b1, 8'h63);
    do_reset();
    for (int n = 0; n < 8; n++) idle(1'b1);
    chk("rst_no_stale", npop, 0);
    send(256'd100, 256'd23, 1'b1, 1'b0, 8'h64);
    for (int n = 0; n < 20 && npop == 0; n++) idle(1'b1);
    chk("lat_after_rst", first_pop - last_acc, ST);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
